// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and state encoding for the SPI frame decoder.
package spi_pkg;
    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;
    localparam int CMD_W = 1 + ADDR_W_DEF;
    localparam int FRAME_W = CMD_W + DATA_W_DEF;
    localparam logic SPI_WR = 1'b1;
    localparam logic SPI_RD = 1'b0;
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
endpackage

// File: rtl/spi_tx_shift.sv
// spi_tx_shift: MISO shift register, parallel load wins over shift, MSB first.
module spi_tx_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);
    logic [W-1:0] sr;
    always_ff @(posedge clk or negedge rstb)
        if (!rstb) sr <= '0;
        else sr <= load ? din : shift ? {sr[W-2:0], 1'b0} : sr;
    assign msb = sr[W-1];
endmodule

// File: rtl/spi_frame_decoder.sv
// spi_frame_decoder: decodes SPI mode-0 R/W+addr+data frames into register
// write strobes and read requests, and shifts read data out on MISO.
module spi_frame_decoder
    import spi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              cs_n,
    input  logic              mosi,
    input  logic              sclk_pos,
    input  logic              sclk_neg,
    output logic              miso,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              frame_err
);
    localparam int CW = 1 + ADDR_W;
    localparam int FW = CW + DATA_W;
    localparam int NW = $clog2(FW + 1);

    state_t            state, state_nx;
    logic [NW-1:0]     cnt;
    logic [CW-1:0]     cmd_sr, cmd_nx;
    logic [DATA_W-1:0] dat_sr, dat_nx;
    logic              rw, rd_en_d, tx_msb;
    logic              sample, abort, last_cmd, last_dat, tx_shift;

    always_comb begin
        sample   = ena && sclk_pos && !cs_n;
        abort    = ena && cs_n && (state == CMD || state == DATA);
        last_cmd = sample && state == CMD && cnt == NW'(CW - 1);
        last_dat = sample && state == DATA && cnt == NW'(FW - 1);
        cmd_nx   = {cmd_sr[CW-2:0], mosi};
        dat_nx   = {dat_sr[DATA_W-2:0], mosi};
        // Shift only after the first data bit so bit 0 stays on MISO for its rising edge
        tx_shift = ena && sclk_neg && !sclk_pos && state == DATA && cnt > NW'(CW);
        miso     = (state == DATA && rw == SPI_RD) ? tx_msb : 1'b0;
        state_nx = state;
        if (ena)
            case (state)
                IDLE:    state_nx = cs_n ? IDLE : CMD;
                CMD:     state_nx = abort ? IDLE : last_cmd ? DATA : CMD;
                DATA:    state_nx = abort ? IDLE : last_dat ? DONE : DATA;
                default: state_nx = cs_n ? IDLE : DONE;
            endcase
    end

    always_ff @(posedge clk or negedge rstb)
        if (!rstb) state <= IDLE;
        else state <= state_nx;

    always_ff @(posedge clk or negedge rstb)
        if (!rstb) begin
            cnt       <= '0;
            cmd_sr    <= '0;
            dat_sr    <= '0;
            rw        <= 1'b0;
            rd_en_d   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            rd_en_d <= rd_en;
            if (ena) begin
                if (state == IDLE) begin
                    cnt <= '0;
                    if (!cs_n) frame_err <= 1'b0;
                end
                if (abort) frame_err <= 1'b1;
                if (sample && (state == CMD || state == DATA)) cnt <= cnt + 1'b1;
                if (sample && state == CMD) cmd_sr <= cmd_nx;
                if (sample && state == DATA) dat_sr <= dat_nx;
                if (last_cmd) begin
                    rw <= cmd_nx[CW-1];
                    if (cmd_nx[CW-1] == SPI_RD) begin
                        rd_en   <= 1'b1;
                        rd_addr <= cmd_nx[ADDR_W-1:0];
                    end
                end
                if (last_dat && rw == SPI_WR) begin
                    wr_en   <= 1'b1;
                    wr_addr <= cmd_sr[ADDR_W-1:0];
                    wr_data <= dat_nx;
                end
            end
        end

    spi_tx_shift #(.W(DATA_W)) u_tx (
        .clk   (clk),
        .rstb  (rstb),
        .load  (rd_en_d),
        .shift (tx_shift),
        .din   (rd_data),
        .msb   (tx_msb)
    );
endmodule

// File: tb/tb_spi_frame_decoder.sv
// tb_spi_frame_decoder: directed plus random SPI frames checked against a field-level model.
module tb_spi_frame_decoder;
    logic       clk = 1'b0, rstb = 1'b0, ena = 1'b1, cs_n = 1'b1, mosi = 1'b0;
    logic       sclk_pos = 1'b0, sclk_neg = 1'b0;
    logic       miso, wr_en, rd_en, frame_err;
    logic [6:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data = 8'h00;
    logic [7:0] mem [128];
    int         n_cmp = 0, n_bad = 0;
    int         wr_cnt = 0, rd_cnt = 0;
    logic [6:0] wa = '0;
    logic [7:0] wd = '0;

    spi_frame_decoder dut (
        .clk(clk), .rstb(rstb), .ena(ena), .cs_n(cs_n), .mosi(mosi),
        .sclk_pos(sclk_pos), .sclk_neg(sclk_neg), .miso(miso),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Register bank: returns data the cycle after rd_en, records write strobes
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            rd_cnt  <= rd_cnt + 1;
        end
        if (wr_en) begin
            wr_cnt <= wr_cnt + 1;
            wa     <= wr_addr;
            wd     <= wr_data;
        end
    end

    task automatic chk(input string tag, input int o, input int e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic sbit(input logic b, input logic en, output logic m);
        @(negedge clk) mosi = b; ena = en;
        repeat (2) @(negedge clk);
        m = miso;
        sclk_pos = 1'b1;
        @(negedge clk) sclk_pos = 1'b0; ena = 1'b1;
        repeat (2) @(negedge clk);
        ena = en; sclk_neg = 1'b1;
        @(negedge clk) sclk_neg = 1'b0; ena = 1'b1;
        @(negedge clk);
    endtask

    task automatic frame(input logic [31:0] v, input int n, input int dis_at,
                         input bit raise_cs, output logic [7:0] mb);
        logic m;
        mb = '0;
        @(negedge clk) cs_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i == dis_at)
                for (int j = 0; j < 5; j++) sbit(1'($urandom), 1'b0, m);
            sbit(v[n-1-i], 1'b1, m);
            if (i >= 8 && i < 16) mb[15-i] = m;
        end
        repeat (3) @(negedge clk);
        if (raise_cs) cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_miso"}, 32'(miso), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_frame_err"}, 32'(frame_err), 0);
    endtask

    // Field-level expectation for one complete frame f
    task automatic check_frame(input string tag, input logic [15:0] f, input int wr0,
                               input int rd0, input logic [7:0] mb);
        int a, d;
        a = (int'(f) >> 8) & 'h7F;
        d = int'(f) & 'hFF;
        if (f[15]) begin
            chk({tag, "_wr_cnt"}, wr_cnt, wr0 + 1);
            chk({tag, "_wr_addr"}, 32'(wa), a);
            chk({tag, "_wr_data"}, 32'(wd), d);
            chk({tag, "_wr_hold"}, 32'(wr_addr), a);
            chk({tag, "_rd_cnt"}, rd_cnt, rd0);
        end else begin
            chk({tag, "_rd_cnt"}, rd_cnt, rd0 + 1);
            chk({tag, "_rd_addr"}, 32'(rd_addr), a);
            chk({tag, "_miso"}, 32'(mb), 32'(mem[a]));
            chk({tag, "_wr_cnt"}, wr_cnt, wr0);
        end
        chk({tag, "_ferr"}, 32'(frame_err), 0);
    endtask

    initial begin
        logic [7:0]  mb;
        logic [15:0] f;
        logic        m;
        int          w0, r0;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[3] = 8'h3C;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rstb = 1'b1;
        repeat (2) @(negedge clk);

        w0 = wr_cnt; r0 = rd_cnt;
        frame(32'h85A5, 16, -1, 1'b1, mb);
        check_frame("wr85A5", 16'h85A5, w0, r0, mb);

        w0 = wr_cnt; r0 = rd_cnt;
        frame(32'h0300, 16, -1, 1'b1, mb);
        check_frame("rd0300", 16'h0300, w0, r0, mb);
        chk("rd0300_bits", 32'(mb), 'h3C);

        w0 = wr_cnt;
        frame(32'h8AB7 >> 6, 10, -1, 1'b1, mb);
        chk("abort_ferr", 32'(frame_err), 1);
        chk("abort_no_wr", wr_cnt, w0);
        @(negedge clk) cs_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_ferr_clr", 32'(frame_err), 0);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        w0 = wr_cnt; r0 = rd_cnt;
        frame(32'h9234, 16, -1, 1'b1, mb);
        check_frame("after_abort", 16'h9234, w0, r0, mb);

        w0 = wr_cnt; r0 = rd_cnt;
        frame({12'h0, 16'hFF12, 4'hF}, 20, -1, 1'b0, mb);
        chk("extra_busy_ena", 32'(wr_cnt), w0 + 1);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check_frame("extra20", 16'hFF12, w0, r0, mb);

        w0 = wr_cnt; r0 = rd_cnt;
        frame(32'h8C5A, 16, 6, 1'b1, mb);
        check_frame("ena_low", 16'h8C5A, w0, r0, mb);

        @(negedge clk) cs_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 7; i++) sbit(1'($urandom), 1'b1, m);
        rstb = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk) cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        w0 = wr_cnt; r0 = rd_cnt;
        frame(32'h8101, 16, -1, 1'b1, mb);
        check_frame("post_reset", 16'h8101, w0, r0, mb);

        for (int k = 0; k < 10; k++) begin
            f = 16'($urandom);
            w0 = wr_cnt; r0 = rd_cnt;
            frame({16'h0, f}, 16, -1, 1'b1, mb);
            check_frame("rand", f, w0, r0, mb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
